issue_unit: RTL and testbench
=============================

ISSUE_UNIT -- requirements
Module: issue_unit

Interface
REQ-001 Parameter NUM_RS, default 3: number of ALU reservation stations served; station k has tag RS_TAGS[k], so k=0 is ALU_1.
REQ-002 Parameter NUM_REGS, default 32: architectural register count; register 0 reads zero.
REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 reset_ni  in  1  asynchronous, active-low reset.
REQ-005 in_valid_i  in  1  a decoded instruction is offered.
REQ-006 in_ready_o  out  1  the instruction buffer accepts the offered instruction this cycle.
REQ-007 in_rd_i, in_rs1_i, in_rs2_i  in  5 each  destination and source register indices.
REQ-008 in_imm_i  in  32  immediate; in_use_imm_i  in  1  operand 2 comes from the immediate instead of rs2.
REQ-009 in_alu_op_i  in  alu_op_t; in_shift_op_i  in  shift_op_t; in_spec_i  in  1  speculative flag.
REQ-010 cdb_i  in  cdb_t  common data bus (tag, val).
REQ-011 rs_busy_i  in  NUM_RS  busy_o from each station.
REQ-012 rs_write_o  out  NUM_RS  one-hot write strobe, or zero.
REQ-013 rs_tag1_o, rs_tag2_o  out  rs_tag_t  operand tags; rs_value1_o, rs_value2_o  out  word32_t  operand values.
REQ-014 rs_alu_op_o, rs_shift_op_o, rs_spec_o  out  copies of the buffered instruction fields, shared by all stations.

Function
REQ-015 A one-entry instruction buffer SHALL implement the states EMPTY and FULL.
REQ-016 Buffer load: in_valid_i & in_ready_o loads the buffer; in_ready_o SHALL equal (EMPTY | issue_fire) and is combinational.
REQ-017 Issue: issue_fire = FULL & (some rs_busy_i bit is 0); the lowest-index non-busy station is selected and its rs_write_o bit is asserted in that cycle only.
REQ-018 Buffer transitions: FULL with no issue_fire stays FULL and holds its contents; issue_fire without a load goes to EMPTY; issue_fire with a load stays FULL with the new instruction (one issue per cycle sustained).
REQ-019 Operand lookup: a source is ready when its register tag is NO_VAL; the output is then (NO_VAL, regfile value).
REQ-020 Operand lookup: a source is pending when its register tag is not NO_VAL; the output is then (that tag, 0).
REQ-021 CDB bypass: if cdb_i.tag is not NO_VAL and equals a pending source tag in the issue cycle, the output is (NO_VAL, cdb_i.val).
REQ-022 Immediate operand: when use_imm is set, operand 2 SHALL be (NO_VAL, imm) regardless of rs2; a source of register 0 SHALL always be (NO_VAL, 0).
REQ-023 Rename: on issue_fire with rd != 0, reg_tag[rd] <= tag of the selected station.
REQ-024 Writeback: for every register r with reg_tag[r] == cdb_i.tag (not NO_VAL), regfile[r] <= cdb_i.val and reg_tag[r] <= NO_VAL.
REQ-025 Simultaneous rename and writeback of the same rd: regfile[rd] takes the CDB value, and reg_tag[rd] takes the new station tag (rename wins).
REQ-026 rs_write_o SHALL be zero whenever the buffer is EMPTY, and SHALL never have more than one bit set.
REQ-027 Width: regfile entries are 32 bits; no arithmetic is performed here.

Reset
REQ-028 While reset_ni is low, asynchronously: buffer EMPTY, every reg_tag = NO_VAL, every regfile entry = 0.
REQ-029 During reset, rs_write_o = 0 and in_ready_o = 1.
REQ-030 A reset mid-operation SHALL discard the buffered instruction, with no rs_write_o pulse.

Structure
REQ-031 The RS_TAGS array and an issue_instr_t struct (rd, rs1, rs2, imm, use_imm, alu_op, shift_op, spec) SHALL live in data_types.
REQ-032 One sub-module, reg_status_file, SHALL hold the regfile and reg_tag arrays with two lookup ports, the rename port and CDB writeback.
REQ-033 The free-station priority selection SHALL stay in issue_unit.

Verification
REQ-034 Independent op: after reset, issue ADD r3 <- r1,r2 with rs_busy_i=000 -> rs_write_o=001, tag1=tag2=NO_VAL, values 0,0; next cycle reg_tag[3]=ALU_1.
REQ-035 Dependent op: issue r4 <- r3+r3 while reg_tag[3]=ALU_1 -> tag1=tag2=ALU_1.
REQ-036 CDB writeback: CDB (ALU_1, 0x55) arrives -> regfile[3]=0x55 and reg_tag[3]=NO_VAL next cycle.
REQ-037 Bypass: CDB (ALU_2, 0xA5) in the same cycle that an instruction sourcing r5 (reg_tag[5]=ALU_2) issues -> (NO_VAL, 0xA5).
REQ-038 All stations busy: rs_busy_i=111 with two back-to-back instructions -> first held, in_ready_o=0, no write.
REQ-039 Release: rs_busy_i then goes to 101 -> rs_write_o=010 that cycle and in_ready_o=1.
REQ-040 Collision: CDB (ALU_1, 7) for r3 in the same cycle a new instruction issues to ALU_3 writing r3 -> regfile[3]=7, reg_tag[3]=ALU_3.
REQ-041 Immediate and zero register: use_imm with imm=0xFFFF_FFFF and rs1=0 -> (NO_VAL, 0) and (NO_VAL, 0xFFFF_FFFF).
REQ-042 Rename of register 0: rd=0 -> reg_tag[0] stays NO_VAL.
REQ-043 Async reset: assert reset_ni low mid-clock with the buffer FULL -> rs_write_o=0 immediately, all tags cleared.

Source files
------------

// File: rtl/data_types.sv
// data_types: shared tags, bus and instruction types for the issue stage.
package data_types;
    typedef logic [31:0] word32_t;
    typedef enum logic [2:0] {NO_VAL, ALU_1, ALU_2, ALU_3, ALU_4, ALU_5, ALU_6, ALU_7} rs_tag_t;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SHIFT} alu_op_t;
    typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shift_op_t;
    typedef struct packed {
        rs_tag_t tag;
        word32_t val;
    } cdb_t;
    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        word32_t    imm;
        logic       use_imm;
        alu_op_t    alu_op;
        shift_op_t  shift_op;
        logic       spec;
    } issue_instr_t;
    localparam rs_tag_t RS_TAGS [7] = '{ALU_1, ALU_2, ALU_3, ALU_4, ALU_5, ALU_6, ALU_7};
    // A pending source whose producer is on the CDB this cycle is taken from the bus.
    function automatic cdb_t resolve_operand(input rs_tag_t tag, input word32_t val, input cdb_t cdb);
        return tag == NO_VAL ? cdb_t'{NO_VAL, val} :
               tag == cdb.tag ? cdb_t'{NO_VAL, cdb.val} : cdb_t'{tag, '0};
    endfunction
endpackage

// File: rtl/reg_status_file.sv
// reg_status_file: register values and producer tags with two lookups, rename and CDB writeback.
module reg_status_file import data_types::*; #(
    parameter int NUM_REGS = 32
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [4:0] rd_addr1_i,
    input  logic [4:0] rd_addr2_i,
    output rs_tag_t    tag1_o,
    output word32_t    val1_o,
    output rs_tag_t    tag2_o,
    output word32_t    val2_o,
    input  logic       ren_en_i,
    input  logic [4:0] ren_addr_i,
    input  rs_tag_t    ren_tag_i,
    input  cdb_t       cdb_i
);
    word32_t regfile [NUM_REGS];
    rs_tag_t reg_tag [NUM_REGS];
    assign tag1_o = reg_tag[rd_addr1_i];
    assign val1_o = regfile[rd_addr1_i];
    assign tag2_o = reg_tag[rd_addr2_i];
    assign val2_o = regfile[rd_addr2_i];
    // Rename is applied after writeback so a same-cycle rename of rd keeps the new tag.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regfile[r] <= '0;
                reg_tag[r] <= NO_VAL;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (cdb_i.tag != NO_VAL && reg_tag[r] == cdb_i.tag) begin
                    regfile[r] <= cdb_i.val;
                    reg_tag[r] <= NO_VAL;
                end
            end
            if (ren_en_i && ren_addr_i != '0)
                reg_tag[ren_addr_i] <= ren_tag_i;
        end
    end
endmodule

// File: rtl/issue_unit.sv
// issue_unit: one-entry instruction buffer issuing to the lowest free ALU reservation station.
module issue_unit import data_types::*; #(
    parameter int NUM_RS   = 3,
    parameter int NUM_REGS = 32
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [4:0]        in_rd_i,
    input  logic [4:0]        in_rs1_i,
    input  logic [4:0]        in_rs2_i,
    input  word32_t           in_imm_i,
    input  logic              in_use_imm_i,
    input  alu_op_t           in_alu_op_i,
    input  shift_op_t         in_shift_op_i,
    input  logic              in_spec_i,
    input  cdb_t              cdb_i,
    input  logic [NUM_RS-1:0] rs_busy_i,
    output logic [NUM_RS-1:0] rs_write_o,
    output rs_tag_t           rs_tag1_o,
    output rs_tag_t           rs_tag2_o,
    output word32_t           rs_value1_o,
    output word32_t           rs_value2_o,
    output alu_op_t           rs_alu_op_o,
    output shift_op_t         rs_shift_op_o,
    output logic              rs_spec_o
);
    typedef enum logic {EMPTY, FULL} buf_state_t;
    buf_state_t        state;
    issue_instr_t      instr;
    logic [NUM_RS-1:0] free, grant;
    logic              fire;
    rs_tag_t           sel_tag, raw_tag1, raw_tag2;
    word32_t           raw_val1, raw_val2;
    cdb_t              op1, op2;
    assign free       = ~rs_busy_i;
    assign grant      = free & (~free + NUM_RS'(1));
    assign fire       = state == FULL && |free;
    assign in_ready_o = state == EMPTY || fire;
    assign rs_write_o = fire ? grant : '0;
    always_comb begin
        sel_tag = NO_VAL;
        for (int k = NUM_RS - 1; k >= 0; k--)
            if (free[k]) sel_tag = RS_TAGS[k];
    end
    reg_status_file #(.NUM_REGS(NUM_REGS)) u_rsf (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .rd_addr1_i (instr.rs1),
        .rd_addr2_i (instr.rs2),
        .tag1_o     (raw_tag1),
        .val1_o     (raw_val1),
        .tag2_o     (raw_tag2),
        .val2_o     (raw_val2),
        .ren_en_i   (fire),
        .ren_addr_i (instr.rd),
        .ren_tag_i  (sel_tag),
        .cdb_i      (cdb_i)
    );
    assign op1           = resolve_operand(raw_tag1, raw_val1, cdb_i);
    assign op2           = instr.use_imm ? cdb_t'{NO_VAL, instr.imm} : resolve_operand(raw_tag2, raw_val2, cdb_i);
    assign rs_tag1_o     = op1.tag;
    assign rs_value1_o   = op1.val;
    assign rs_tag2_o     = op2.tag;
    assign rs_value2_o   = op2.val;
    assign rs_alu_op_o   = instr.alu_op;
    assign rs_shift_op_o = instr.shift_op;
    assign rs_spec_o     = instr.spec;
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= EMPTY;
            instr <= '0;
        end else if (in_valid_i && in_ready_o) begin
            state <= FULL;
            instr <= '{in_rd_i, in_rs1_i, in_rs2_i, in_imm_i, in_use_imm_i, in_alu_op_i, in_shift_op_i, in_spec_i};
        end else if (fire) begin
            state <= EMPTY;
        end
    end
endmodule

// File: tb/tb_issue_unit.sv
// tb_issue_unit: directed scenarios for the issue buffer, renaming, CDB bypass and reset.
module tb_issue_unit;
    import data_types::*;
    logic       clk_i = 0, reset_ni = 0, in_valid_i = 0, in_ready_o;
    logic [4:0] in_rd_i = 0, in_rs1_i = 0, in_rs2_i = 0;
    word32_t    in_imm_i = 0;
    logic       in_use_imm_i = 0, in_spec_i = 0;
    alu_op_t    in_alu_op_i = ALU_ADD;
    shift_op_t  in_shift_op_i = SH_SLL;
    cdb_t       cdb_i = '0;
    logic [2:0] rs_busy_i = 0, rs_write_o;
    rs_tag_t    rs_tag1_o, rs_tag2_o;
    word32_t    rs_value1_o, rs_value2_o;
    alu_op_t    rs_alu_op_o;
    shift_op_t  rs_shift_op_o;
    logic       rs_spec_o;
    int         tests = 0, fails = 0;

    issue_unit dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_rd_i(in_rd_i), .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_imm_i(in_imm_i),
        .in_use_imm_i(in_use_imm_i), .in_alu_op_i(in_alu_op_i), .in_shift_op_i(in_shift_op_i),
        .in_spec_i(in_spec_i), .cdb_i(cdb_i), .rs_busy_i(rs_busy_i), .rs_write_o(rs_write_o),
        .rs_tag1_o(rs_tag1_o), .rs_tag2_o(rs_tag2_o), .rs_value1_o(rs_value1_o),
        .rs_value2_o(rs_value2_o), .rs_alu_op_o(rs_alu_op_o), .rs_shift_op_o(rs_shift_op_o),
        .rs_spec_o(rs_spec_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic offer(input logic [4:0] rd, rs1, rs2, input word32_t imm, input logic use_imm,
                         input alu_op_t op, input shift_op_t sh, input logic spec);
        in_valid_i = 1; in_rd_i = rd; in_rs1_i = rs1; in_rs2_i = rs2; in_imm_i = imm;
        in_use_imm_i = use_imm; in_alu_op_i = op; in_shift_op_i = sh; in_spec_i = spec;
    endtask

    task automatic test_reset;
        reset_ni = 0; #2;
        tests++; if (rs_write_o !== 3'b000) begin fails++; $display("FAIL reset_write: got %b want 000", rs_write_o); end
        tests++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", in_ready_o); end
        tests++; if (dut.u_rsf.reg_tag[3] !== NO_VAL) begin fails++; $display("FAIL reset_tag3: got %0d want 0", dut.u_rsf.reg_tag[3]); end
        tests++; if (dut.u_rsf.regfile[31] !== 32'h0) begin fails++; $display("FAIL reset_reg31: got %h want 0", dut.u_rsf.regfile[31]); end
        @(negedge clk_i); @(negedge clk_i); reset_ni = 1;
    endtask

    task automatic test_independent;
        @(negedge clk_i); rs_busy_i = 3'b000; offer(3, 1, 2, 0, 0, ALU_ADD, SH_SLL, 0);
        @(negedge clk_i); in_valid_i = 0; #1;
        tests++; if (rs_write_o !== 3'b001) begin fails++; $display("FAIL indep_write: got %b want 001", rs_write_o); end
        tests++; if (rs_tag1_o !== NO_VAL || rs_tag2_o !== NO_VAL) begin fails++; $display("FAIL indep_tags: got %0d,%0d want 0,0", rs_tag1_o, rs_tag2_o); end
        tests++; if (rs_value1_o !== 0 || rs_value2_o !== 0) begin fails++; $display("FAIL indep_vals: got %h,%h want 0,0", rs_value1_o, rs_value2_o); end
        tests++; if (rs_alu_op_o !== ALU_ADD) begin fails++; $display("FAIL indep_op: got %0d want %0d", rs_alu_op_o, ALU_ADD); end
        @(negedge clk_i);
        tests++; if (dut.u_rsf.reg_tag[3] !== ALU_1) begin fails++; $display("FAIL indep_rename: got %0d want %0d", dut.u_rsf.reg_tag[3], ALU_1); end
        tests++; if (rs_write_o !== 3'b000) begin fails++; $display("FAIL indep_empty_write: got %b want 000", rs_write_o); end
    endtask

    task automatic test_dependent;
        rs_busy_i = 3'b001; offer(4, 3, 3, 0, 0, ALU_ADD, SH_SLL, 0);
        @(negedge clk_i); in_valid_i = 0; #1;
        tests++; if (rs_write_o !== 3'b010) begin fails++; $display("FAIL dep_write: got %b want 010", rs_write_o); end
        tests++; if (rs_tag1_o !== ALU_1 || rs_tag2_o !== ALU_1) begin fails++; $display("FAIL dep_tags: got %0d,%0d want 1,1", rs_tag1_o, rs_tag2_o); end
        tests++; if (rs_value1_o !== 0 || rs_value2_o !== 0) begin fails++; $display("FAIL dep_vals: got %h,%h want 0,0", rs_value1_o, rs_value2_o); end
        @(negedge clk_i);
        tests++; if (dut.u_rsf.reg_tag[4] !== ALU_2) begin fails++; $display("FAIL dep_rename: got %0d want %0d", dut.u_rsf.reg_tag[4], ALU_2); end
    endtask

    task automatic test_cdb_writeback;
        cdb_i = cdb_t'{ALU_1, 32'h55};
        @(negedge clk_i); cdb_i = '0;
        tests++; if (dut.u_rsf.regfile[3] !== 32'h55) begin fails++; $display("FAIL wb_val: got %h want 55", dut.u_rsf.regfile[3]); end
        tests++; if (dut.u_rsf.reg_tag[3] !== NO_VAL) begin fails++; $display("FAIL wb_tag: got %0d want 0", dut.u_rsf.reg_tag[3]); end
        tests++; if (dut.u_rsf.reg_tag[4] !== ALU_2) begin fails++; $display("FAIL wb_other_tag: got %0d want %0d", dut.u_rsf.reg_tag[4], ALU_2); end
    endtask

    task automatic test_bypass;
        rs_busy_i = 3'b001; offer(5, 0, 0, 32'h10, 1, ALU_ADD, SH_SLL, 0);
        @(negedge clk_i); offer(6, 5, 4, 0, 0, ALU_OR, SH_SLL, 0);
        @(negedge clk_i); in_valid_i = 0; rs_busy_i = 3'b000; cdb_i = cdb_t'{ALU_2, 32'hA5}; #1;
        tests++; if (rs_write_o !== 3'b001) begin fails++; $display("FAIL byp_write: got %b want 001", rs_write_o); end
        tests++; if (rs_tag1_o !== NO_VAL || rs_value1_o !== 32'hA5) begin fails++; $display("FAIL byp_op1: got %0d/%h want 0/a5", rs_tag1_o, rs_value1_o); end
        tests++; if (rs_tag2_o !== NO_VAL || rs_value2_o !== 32'hA5) begin fails++; $display("FAIL byp_op2: got %0d/%h want 0/a5", rs_tag2_o, rs_value2_o); end
        @(negedge clk_i); cdb_i = '0;
        tests++; if (dut.u_rsf.regfile[5] !== 32'hA5 || dut.u_rsf.reg_tag[5] !== NO_VAL) begin fails++; $display("FAIL byp_wb5: got %h/%0d want a5/0", dut.u_rsf.regfile[5], dut.u_rsf.reg_tag[5]); end
        tests++; if (dut.u_rsf.reg_tag[6] !== ALU_1) begin fails++; $display("FAIL byp_rename6: got %0d want %0d", dut.u_rsf.reg_tag[6], ALU_1); end
    endtask

    task automatic test_all_busy;
        rs_busy_i = 3'b111; offer(7, 3, 1, 0, 0, ALU_SHIFT, SH_SRA, 1);
        @(negedge clk_i); offer(8, 7, 2, 0, 0, ALU_SUB, SH_SLL, 0); #1;
        tests++; if (in_ready_o !== 1'b0 || rs_write_o !== 3'b000) begin fails++; $display("FAIL busy_hold1: got ready=%b write=%b want 0/000", in_ready_o, rs_write_o); end
        @(negedge clk_i); #1;
        tests++; if (in_ready_o !== 1'b0 || rs_write_o !== 3'b000) begin fails++; $display("FAIL busy_hold2: got ready=%b write=%b want 0/000", in_ready_o, rs_write_o); end
        rs_busy_i = 3'b101; #1;
        tests++; if (rs_write_o !== 3'b010 || in_ready_o !== 1'b1) begin fails++; $display("FAIL release: got write=%b ready=%b want 010/1", rs_write_o, in_ready_o); end
        tests++; if (rs_tag1_o !== NO_VAL || rs_value1_o !== 32'h55 || rs_spec_o !== 1'b1 || rs_shift_op_o !== SH_SRA) begin fails++; $display("FAIL release_fields: got %0d/%h spec=%b sh=%0d want 0/55 1 2", rs_tag1_o, rs_value1_o, rs_spec_o, rs_shift_op_o); end
        @(negedge clk_i); in_valid_i = 0; rs_busy_i = 3'b000; #1;
        tests++; if (rs_write_o !== 3'b001 || rs_tag1_o !== ALU_2 || rs_alu_op_o !== ALU_SUB) begin fails++; $display("FAIL b2b_second: got write=%b tag1=%0d op=%0d want 001/2/1", rs_write_o, rs_tag1_o, rs_alu_op_o); end
        @(negedge clk_i);
        tests++; if (rs_write_o !== 3'b000 || in_ready_o !== 1'b1) begin fails++; $display("FAIL b2b_drain: got write=%b ready=%b want 000/1", rs_write_o, in_ready_o); end
    endtask

    task automatic test_collision;
        offer(3, 1, 2, 0, 0, ALU_ADD, SH_SLL, 0);
        @(negedge clk_i); offer(3, 1, 2, 0, 0, ALU_XOR, SH_SLL, 0);
        @(negedge clk_i); in_valid_i = 0; rs_busy_i = 3'b011; cdb_i = cdb_t'{ALU_1, 32'h7}; #1;
        tests++; if (rs_write_o !== 3'b100) begin fails++; $display("FAIL coll_write: got %b want 100", rs_write_o); end
        @(negedge clk_i); cdb_i = '0; rs_busy_i = 3'b000;
        tests++; if (dut.u_rsf.regfile[3] !== 32'h7 || dut.u_rsf.reg_tag[3] !== ALU_3) begin fails++; $display("FAIL coll_r3: got %h/%0d want 7/3", dut.u_rsf.regfile[3], dut.u_rsf.reg_tag[3]); end
    endtask

    task automatic test_imm_zero;
        offer(0, 0, 3, 32'hFFFF_FFFF, 1, ALU_AND, SH_SLL, 0);
        @(negedge clk_i); in_valid_i = 0; #1;
        tests++; if (rs_tag1_o !== NO_VAL || rs_value1_o !== 32'h0) begin fails++; $display("FAIL zero_op1: got %0d/%h want 0/0", rs_tag1_o, rs_value1_o); end
        tests++; if (rs_tag2_o !== NO_VAL || rs_value2_o !== 32'hFFFF_FFFF) begin fails++; $display("FAIL imm_op2: got %0d/%h want 0/ffffffff", rs_tag2_o, rs_value2_o); end
        @(negedge clk_i);
        tests++; if (dut.u_rsf.reg_tag[0] !== NO_VAL || dut.u_rsf.regfile[0] !== 0) begin fails++; $display("FAIL rename_r0: got %0d/%h want 0/0", dut.u_rsf.reg_tag[0], dut.u_rsf.regfile[0]); end
    endtask

    task automatic test_async_reset;
        offer(9, 1, 2, 0, 0, ALU_ADD, SH_SLL, 0);
        @(posedge clk_i); #2;
        tests++; if (rs_write_o !== 3'b001) begin fails++; $display("FAIL pre_reset_write: got %b want 001", rs_write_o); end
        #1 reset_ni = 0; #1;
        tests++; if (rs_write_o !== 3'b000 || in_ready_o !== 1'b1) begin fails++; $display("FAIL async_reset: got write=%b ready=%b want 000/1", rs_write_o, in_ready_o); end
        tests++; if (dut.u_rsf.reg_tag[3] !== NO_VAL || dut.u_rsf.regfile[3] !== 0) begin fails++; $display("FAIL async_reset_r3: got %0d/%h want 0/0", dut.u_rsf.reg_tag[3], dut.u_rsf.regfile[3]); end
        @(negedge clk_i); in_valid_i = 0;
        @(negedge clk_i); reset_ni = 1;
        @(negedge clk_i);
        tests++; if (rs_write_o !== 3'b000 || dut.u_rsf.reg_tag[9] !== NO_VAL) begin fails++; $display("FAIL post_reset: got write=%b tag9=%0d want 000/0", rs_write_o, dut.u_rsf.reg_tag[9]); end
    endtask

    initial begin
        test_reset;
        test_independent;
        test_dependent;
        test_cdb_writeback;
        test_bypass;
        test_all_busy;
        test_collision;
        test_imm_zero;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
